hilo_muldiv: RTL
================

HILO_MULDIV -- requirements
Module: hilo_muldiv

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the operand, HI and LO width (legal range 8..64, even).
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a mul/div operation; accepted only when busy=0.
REQ-005 op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 opa, opb  input  WIDTH each  multiplicand/dividend, multiplier/divisor.
REQ-007 cancel  input  1  abort an in-flight operation (pipeline flush).
REQ-008 wehi, welo  input  1 each  direct write enables (MTHI/MTLO).
REQ-009 wdatahi, wdatalo  input  WIDTH each  direct write data.
REQ-010 rehi, relo  input  1 each  read enables.
REQ-011 rdatahi, rdatalo  output  WIDTH each  read data.
REQ-012 busy  output  1  operation in flight; pipeline stall request.
REQ-013 done  output  1  one-cycle pulse, HI/LO hold the new result.

Function
REQ-014 The FSM SHALL have states IDLE, MUL and DIV: IDLE->MUL (op 0x) or IDLE->DIV (op 1x) on start; MUL/DIV->IDLE after WIDTH iterations or on cancel.
REQ-015 On acceptance, signed ops SHALL latch operand magnitudes plus result signs; unsigned ops SHALL latch operands as-is.
REQ-016 busy SHALL be 1 in MUL/DIV; start while busy SHALL be ignored.
REQ-017 An iteration counter SHALL count 0..WIDTH-1, one shift-add or restore-subtract step per cycle.
REQ-018 Start accepted at edge E0: HI/LO SHALL be written at edge E_WIDTH, and done SHALL be 1 for exactly the cycle after E_WIDTH.
REQ-019 MULT/MULTU: {HI,LO} SHALL equal the full 2*WIDTH-bit product, two's-complement for MULT.
REQ-020 DIV/DIVU: LO SHALL be the quotient and HI the remainder; DIV truncates toward zero, the remainder takes the dividend's sign.
REQ-021 DIV of the most-negative value by -1 SHALL give LO=most-negative and HI=0, with no exception.
REQ-022 Divide by zero SHALL give LO=all ones and HI=opa, still taking WIDTH cycles.
REQ-023 cancel in MUL/DIV SHALL return to IDLE at the next edge, with HI/LO unchanged and no done pulse; cancel in IDLE has no effect.
REQ-024 wehi/welo in IDLE SHALL update HI/LO at the edge; while busy they SHALL be ignored.
REQ-025 In IDLE, a direct write and start in the same cycle SHALL both take effect; the completed result later overwrites the direct write.
REQ-026 rdatahi SHALL be 0 when rehi=0; otherwise it SHALL be wdatahi when wehi=1 and busy=0 (same-cycle bypass), else HI. The same rule with relo, welo and wdatalo SHALL apply to rdatalo.
REQ-027 Read outputs SHALL be combinational; there SHALL be no combinational path from start or op to busy.

Reset
REQ-028 rst_n low SHALL asynchronously clear HI and LO to 0, the state to IDLE, the counter to 0, and busy and done to 0.
REQ-029 Reset mid-operation SHALL abort it with no done pulse and no partial HI/LO write.
REQ-030 The first start after reset deasserts SHALL be accepted at the first rising edge.

Structure
REQ-031 Shared package hilo_pkg SHALL hold the op encoding constants, the FSM state encoding and the default WIDTH.
REQ-032 The iterative datapath (shared accumulator/shift register, adder/subtractor, counter) SHALL be sub-module hilo_itercore; hilo_muldiv holds the FSM, sign fix-up, HI/LO registers and read logic.
REQ-033 Only one WIDTH+1-bit adder SHALL be used, shared between multiply and divide.

Verification (WIDTH=32)
REQ-034 MULT opa=0xFFFFFFFE(-2), opb=0x00000003 -> done at cycle 33, HI=0xFFFFFFFF, LO=0xFFFFFFFA; busy high for cycles 1..32.
REQ-035 DIV opa=0xFFFFFFF9(-7), opb=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 -> LO=0xFFFFFFFF, HI=0x00000007.
REQ-036 DIV 0x80000000 by 0xFFFFFFFF -> LO=0x80000000, HI=0; MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-037 HI=0x11 preset, start MULTU, cancel at cycle 10 -> busy drops at cycle 11, HI=0x11, no done; a wehi issued at cycle 5 is ignored.
REQ-038 In IDLE: wehi=1, wdatahi=0xA5A5A5A5, rehi=1 -> rdatahi=0xA5A5A5A5 the same cycle; rehi=0 -> rdatahi=0.
REQ-039 rst_n asserted at cycle 15 of DIV -> busy=0, done=0, HI=LO=0 immediately; a new start after release completes normally.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encoding,
// FSM state encoding and default datapath width.
package hilo_pkg;

  localparam int HILO_WIDTH_DEF = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } hilo_state_e;

endpackage

// File: rtl/hilo_itercore.sv
// Iterative unsigned datapath: shift-add multiply / restoring divide over a
// shared accumulator pair, one step per cycle, with a 0..WIDTH-1 step counter.
module hilo_itercore
  import hilo_pkg::*;
#(
  parameter int WIDTH = HILO_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] load_m,
  input  logic [WIDTH-1:0] load_q,
  output logic             last,
  output logic [WIDTH-1:0] nxt_hi,
  output logic [WIDTH-1:0] nxt_lo
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   add_a;
  logic [WIDTH:0]   add_b;
  logic             cin;
  logic [WIDTH+1:0] sum;

  assign last = (cnt == CW'(WIDTH - 1));

  // Single adder: multiply adds the multiplicand to the upper half, divide
  // subtracts the divisor from the shifted partial remainder (carry = no borrow).
  always_comb begin
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    if (is_div) begin
      add_a = shifted;
      add_b = ~{1'b0, m};
      cin   = 1'b1;
    end else begin
      add_a = {1'b0, acc_hi};
      add_b = {1'b0, m};
      cin   = 1'b0;
    end
  end

  assign sum = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, cin};

  always_comb begin
    nxt_hi = acc_hi;
    nxt_lo = acc_lo;
    if (is_div) begin
      if (sum[WIDTH+1]) begin
        nxt_hi = sum[WIDTH-1:0];
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        nxt_hi = shifted[WIDTH-1:0];
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else if (acc_lo[0]) begin
      nxt_hi = sum[WIDTH:1];
      nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
    end else begin
      nxt_hi = {1'b0, acc_hi[WIDTH-1:1]};
      nxt_lo = {acc_hi[0], acc_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      m      <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
    end else if (load) begin
      cnt    <= '0;
      m      <= load_m;
      acc_hi <= '0;
      acc_lo <= load_q;
    end else if (step) begin
      cnt    <= cnt + 1'b1;
      acc_hi <= nxt_hi;
      acc_lo <= nxt_lo;
    end
  end

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO multiply/divide unit: control FSM, operand sign handling and result
// fix-up, HI/LO registers with direct write and bypassed combinational reads.
//  state | meaning
//  IDLE  | nothing in flight; direct writes and new starts accepted
//  MUL   | WIDTH shift-add steps on operand magnitudes
//  DIV   | WIDTH restore-subtract steps on operand magnitudes
module hilo_muldiv
  import hilo_pkg::*;
#(
  parameter int WIDTH = HILO_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             cancel,
  input  logic             wehi,
  input  logic             welo,
  input  logic [WIDTH-1:0] wdatahi,
  input  logic [WIDTH-1:0] wdatalo,
  input  logic             rehi,
  input  logic             relo,
  output logic [WIDTH-1:0] rdatahi,
  output logic [WIDTH-1:0] rdatalo,
  output logic             busy,
  output logic             done
);

  hilo_state_e      state;
  hilo_state_e      state_nxt;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             q_neg;
  logic             r_neg;
  logic             div_zero;
  logic             op_div;
  logic             op_signed;
  logic             accept;
  logic             last;
  logic             finish;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] nxt_hi;
  logic [WIDTH-1:0] nxt_lo;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  assign op_div    = (op == OP_DIV) || (op == OP_DIVU);
  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign mag_a     = (op_signed && opa[WIDTH-1]) ? -opa : opa;
  assign mag_b     = (op_signed && opb[WIDTH-1]) ? -opb : opb;

  assign busy   = (state != ST_IDLE);
  assign accept = !busy && start;
  assign finish = busy && !cancel && last;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = op_div ? ST_DIV : ST_MUL;
      ST_MUL,
      ST_DIV:  if (cancel || last) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Magnitude result is corrected here; divide by zero forces an all-ones quotient.
  always_comb begin
    res_hi = nxt_hi;
    res_lo = nxt_lo;
    if (state == ST_DIV) begin
      if (div_zero)   res_lo = '1;
      else if (q_neg) res_lo = -nxt_lo;
      if (r_neg)      res_hi = -nxt_hi;
    end else if (q_neg) begin
      {res_hi, res_lo} = -{nxt_hi, nxt_lo};
    end
  end

  hilo_itercore #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept),
    .step   (busy),
    .is_div (state == ST_DIV),
    .load_m (op_div ? mag_b : mag_a),
    .load_q (op_div ? mag_a : mag_b),
    .last   (last),
    .nxt_hi (nxt_hi),
    .nxt_lo (nxt_lo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= finish;
      if (finish) begin
        hi <= res_hi;
        lo <= res_lo;
      end else if (!busy) begin
        if (wehi) hi <= wdatahi;
        if (welo) lo <= wdatalo;
      end
      if (accept) begin
        q_neg    <= op_signed && (opa[WIDTH-1] ^ opb[WIDTH-1]);
        r_neg    <= op_signed && op_div && opa[WIDTH-1];
        div_zero <= (opb == '0);
      end
    end
  end

  assign rdatahi = !rehi ? '0 : ((wehi && !busy) ? wdatahi : hi);
  assign rdatalo = !relo ? '0 : ((welo && !busy) ? wdatalo : lo);

endmodule
